instruction_memory_responder: RTL and testbench
===============================================

// Module: instruction_memory_responder
// PURPOSE
//  Slave end of load_interface: serves block-refill requests from the instruction-cache fetch controller.
//  Latches one request, then streams BLOCK_WORD consecutive 32-bit words, one per valid beat, from an internal
//  word-addressed program memory. Sits between the I-cache refill master and on-chip instruction storage.
//  A boot-time write port preloads the memory.
// PARAMETERS
//  BLOCK_WORD  8     words per cache block = beats per request (power of 2, >=2)
//  MEM_WORDS   4096  program memory depth in 32-bit words (power of 2)
//  LATENCY     2     cycles from request sample to first valid beat (>=1)
//  BEAT_GAP    0     idle cycles inserted between consecutive beats (>=0)
// PORTS
//  clk_i                  in   1   clock
//  rst_i                  in   1   reset; synchronous, active-high
//  load_channel.request   in   1   refill request, one-cycle pulse (load_interface.slave)
//  load_channel.address   in   32  byte address of requested block
//  load_channel.valid     out  1   data beat valid, one cycle per word
//  load_channel.data      out  32  instruction word of current beat
//  busy_o                 out  1   request accepted and not yet fully served
//  prog_write_i           in   1   preload write strobe
//  prog_address_i         in   32  preload byte address (bits [1:0] ignored)
//  prog_data_i            in   32  preload word
// BEHAVIOUR
//  Reset: valid=0, data=0, busy_o=0, state=IDLE, counters=0; memory contents NOT cleared.
//  Reset mid-burst: next cycle valid=0, busy_o=0, remaining beats dropped, state=IDLE.
//  Index: word = address[2 +: log2(MEM_WORDS)]; block base = word with low log2(BLOCK_WORD) bits cleared.
//  FSM IDLE: request=1 -> latch base, beat_cnt=0, wait_cnt=LATENCY-1, busy_o=1 next cycle; -> WAIT,
//    or -> BURST directly when LATENCY=1.
//  FSM WAIT: wait_cnt decrements each cycle; at 0 -> BURST. Memory read for beat 0 issued in last WAIT cycle.
//  FSM BURST: valid=1 for one cycle with data=mem[base+beat_cnt]; beat_cnt++; then BEAT_GAP cycles valid=0.
//    After beat BLOCK_WORD-1: -> IDLE, busy_o=0 the following cycle.
//  Timing: request sampled at edge N -> beat 0 valid in cycle N+LATENCY;
//    beat k in cycle N+LATENCY+k*(1+BEAT_GAP).
//  Beats ascend from block base regardless of address offset bits (critical-word-first unsupported).
//  Request while busy_o=1: ignored, no queueing (one outstanding request by protocol).
//  Request in the cycle busy_o falls (IDLE reached): accepted normally (back-to-back allowed).
//  valid and data are registered outputs; data holds last value when valid=0.
//  prog_write_i: writes mem[word] at clock edge, accepted in any state.
//    Same-cycle write to the word being read returns OLD data (read-first).
//  Address index wraps modulo MEM_WORDS; base+beat_cnt never crosses a block, no carry into upper bits.
// CONFIGURATION
//  RESPONDER_BOUNDS_CHECK_EN defined: adds output port load_error_o (1 bit, reset 0).
//    Request with address >= MEM_WORDS*4 -> full burst still issued with data=0 on every beat, and
//    load_error_o=1 on each of those beats. Preload writes out of range are discarded.
//  Not defined: no load_error_o port; upper address bits ignored, index wraps modulo MEM_WORDS.
// TESTING
//  1 Preload mem[8..15]=0x100..0x107; request addr 0x20 (LATENCY=2, BEAT_GAP=0) -> valid cycles N+2..N+9,
//    data 0x100..0x107, busy_o low at N+10.
//  2 Request addr 0x2C (mid-block) -> same 8 beats from word 8, first data 0x100.
//  3 LATENCY=1, BEAT_GAP=2; request addr 0 -> beats at N+1,N+4,...,N+22, 8 total.
//  4 Second request pulsed at N+3 while busy -> ignored, exactly 8 beats, no further valid;
//    request at busy_o fall cycle -> new burst served.
//  5 rst_i=1 after beat 3 -> valid=0 next cycle, busy_o=0, no further beats; memory retains 0x100..0x107.
//  6 With RESPONDER_BOUNDS_CHECK_EN, MEM_WORDS=4096, request addr 0x4000 -> 8 beats data=0,
//    load_error_o=1 each beat; without the macro -> data from mem[0..7].

Source files
------------

// File: rtl/instruction_memory_responder_if.sv
// Refill channel between the I-cache fetch controller (master) and the
// instruction memory responder (slave).
interface load_interface;
  logic        request;
  logic [31:0] address;
  logic        valid;
  logic [31:0] data;

  modport slave (
    input  request,
    input  address,
    output valid,
    output data
  );

  modport master (
    output request,
    output address,
    input  valid,
    input  data
  );
endinterface

// File: rtl/instruction_memory_responder.sv
// Block-refill responder: latches one request and streams BLOCK_WORD words from program memory.
// Optional RESPONDER_BOUNDS_CHECK_EN adds load_error_o and out-of-range request/write handling.
module instruction_memory_responder #(
  parameter int unsigned BLOCK_WORD = 8,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned BEAT_GAP   = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  load_interface.slave load_channel,
  output logic         busy_o,
  input  logic         prog_write_i,
  input  logic [31:0]  prog_address_i,
  input  logic [31:0]  prog_data_i
`ifdef RESPONDER_BOUNDS_CHECK_EN
  ,
  output logic         load_error_o
`endif
);

  localparam int unsigned IdxW  = $clog2(MEM_WORDS);
  localparam int unsigned OffW  = $clog2(BLOCK_WORD);
  localparam int unsigned WaitW = $clog2(LATENCY + 1);
  localparam int unsigned GapW  = (BEAT_GAP > 0) ? $clog2(BEAT_GAP + 1) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StBurst, StDone} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-OffW-1:0]   blk_q, blk_d;
  logic [OffW-1:0]        beat_q, beat_d;
  logic [WaitW-1:0]       wait_q, wait_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic                   valid_q, valid_d;
  logic [31:0]            data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   lerr_q, lerr_d;

  logic [31:0]            mem [MEM_WORDS];
  logic [31:0]            rd_data;
  logic                   oob_req, oob_wr;

`ifdef RESPONDER_BOUNDS_CHECK_EN
  assign oob_req = |load_channel.address[31:IdxW+2];
  assign oob_wr  = |prog_address_i[31:IdxW+2];
`else
  assign oob_req = 1'b0;
  assign oob_wr  = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^{load_channel.address[31:IdxW+2], load_channel.address[OffW+1:0],
                         prog_address_i[31:IdxW+2], prog_address_i[1:0]};

  // Block base concatenated with the beat count: beats never carry out of the block.
  assign rd_data = mem[{blk_q, beat_q}];

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    gap_d   = gap_q;
    valid_d = 1'b0;
    data_d  = data_q;
    err_d   = err_q;
    lerr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_channel.request) begin
          blk_d   = load_channel.address[2+OffW +: IdxW-OffW];
          beat_d  = '0;
          wait_d  = WaitW'(LATENCY - 1);
          gap_d   = '0;
          err_d   = oob_req;
          state_d = (LATENCY == 1) ? StBurst : StWait;
        end
      end
      StWait: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WaitW'(1)) state_d = StBurst;
      end
      StBurst: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          valid_d = 1'b1;
          data_d  = err_q ? 32'h0 : rd_data;
          lerr_d  = err_q;
          beat_d  = beat_q + 1'b1;
          gap_d   = GapW'(BEAT_GAP);
          if (beat_q == OffW'(BLOCK_WORD - 1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      blk_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      lerr_q  <= lerr_d;
    end
  end

  // Memory survives reset; a same-edge beat read sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (prog_write_i && !oob_wr) begin
      mem[prog_address_i[2 +: IdxW]] <= prog_data_i;
    end
  end

  assign load_channel.valid = valid_q;
  assign load_channel.data  = data_q;
  assign busy_o             = busy_q;

`ifdef RESPONDER_BOUNDS_CHECK_EN
  assign load_error_o = lerr_q;
`else
  logic unused_lerr;
  assign unused_lerr = lerr_q;
`endif

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Bench for instruction_memory_responder: two instances (LATENCY=2/BEAT_GAP=0 and
// LATENCY=1/BEAT_GAP=2) checked every cycle against a beat-schedule reference model.
module tb_instruction_memory_responder;

  localparam int BW = 8;
  localparam int MW = 4096;
`ifdef RESPONDER_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        busy0, busy1;
  logic        pw;
  logic [31:0] pa, pd;
  logic        lerr0, lerr1;

  always #5 clk = ~clk;

  load_interface lif0 ();
  load_interface lif1 ();

  instruction_memory_responder #(
    .BLOCK_WORD(8), .MEM_WORDS(4096), .LATENCY(2), .BEAT_GAP(0)
  ) dut0 (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_channel   (lif0),
    .busy_o         (busy0),
    .prog_write_i   (pw),
    .prog_address_i (pa),
    .prog_data_i    (pd)
`ifdef RESPONDER_BOUNDS_CHECK_EN
    ,
    .load_error_o   (lerr0)
`endif
  );

  instruction_memory_responder #(
    .BLOCK_WORD(8), .MEM_WORDS(4096), .LATENCY(1), .BEAT_GAP(2)
  ) dut1 (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_channel   (lif1),
    .busy_o         (busy1),
    .prog_write_i   (pw),
    .prog_address_i (pa),
    .prog_data_i    (pd)
`ifdef RESPONDER_BOUNDS_CHECK_EN
    ,
    .load_error_o   (lerr1)
`endif
  );

`ifndef RESPONDER_BOUNDS_CHECK_EN
  assign lerr0 = 1'b0;
  assign lerr1 = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_valid(input int i);
    return (i == 0) ? lif0.valid : lif1.valid;
  endfunction
  function automatic logic [31:0] get_data(input int i);
    return (i == 0) ? lif0.data : lif1.data;
  endfunction
  function automatic logic get_busy(input int i);
    return (i == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_err(input int i);
    return (i == 0) ? lerr0 : lerr1;
  endfunction

  // ---------------- reference model: beat schedule from request time ----------------
  logic [31:0] model_mem [MW];
  int          cyc = 0;
  int          acc_n     [2] = '{-1000000, -1000000};
  int          busy_last [2] = '{-1000000, -1000000};
  int          base_m    [2];
  bit          oob_m     [2];
  bit          exp_valid [2] = '{0, 0};
  bit          exp_busy  [2] = '{0, 0};
  bit          exp_err   [2] = '{0, 0};
  logic [31:0] exp_data  [2] = '{32'h0, 32'h0};
  int          lat_m     [2] = '{2, 1};
  int          gap_m     [2] = '{0, 2};

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      logic        r;
      logic [31:0] a;
      int          d;
      int          k;
      r = (i == 0) ? lif0.request : lif1.request;
      a = (i == 0) ? lif0.address : lif1.address;
      if (rst) begin
        acc_n[i]     = -1000000;
        busy_last[i] = -1000000;
        exp_valid[i] = 0;
        exp_busy[i]  = 0;
        exp_err[i]   = 0;
        exp_data[i]  = 32'h0;
      end else begin
        // exp_busy still holds the value for the cycle the request was presented in
        if (r && !exp_busy[i]) begin
          acc_n[i]     = cyc;
          base_m[i]    = (int'(a[13:2]) / BW) * BW;
          oob_m[i]     = BC && (a[31:14] != 0);
          busy_last[i] = cyc + lat_m[i] + (BW - 1) * (1 + gap_m[i]);
        end
        exp_busy[i]  = (cyc >= acc_n[i]) && (cyc <= busy_last[i]);
        exp_valid[i] = 0;
        exp_err[i]   = 0;
        d = cyc - acc_n[i] - lat_m[i];
        if (exp_busy[i] && d >= 0 && (d % (1 + gap_m[i])) == 0 && (d / (1 + gap_m[i])) < BW) begin
          k            = d / (1 + gap_m[i]);
          exp_valid[i] = 1;
          exp_err[i]   = oob_m[i];
          exp_data[i]  = oob_m[i] ? 32'h0 : model_mem[(base_m[i] + k) % MW];
        end
      end
    end
    if (pw && !(BC && pa[31:14] != 0)) model_mem[pa[13:2]] = pd;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("m%0d_valid", i), 32'(get_valid(i)), 32'(exp_valid[i]));
      check($sformatf("m%0d_data", i), get_data(i), exp_data[i]);
      check($sformatf("m%0d_busy", i), 32'(get_busy(i)), 32'(exp_busy[i]));
`ifdef RESPONDER_BOUNDS_CHECK_EN
      check($sformatf("m%0d_err", i), 32'(get_err(i)), 32'(exp_err[i]));
`endif
    end
  end

  // ---------------- stimulus helpers (all driven on negedge) ----------------
  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    pw = 1'b1; pa = addr; pd = data;
    @(negedge clk);
    pw = 1'b0;
  endtask

  task automatic set_req(input int i, input logic r, input logic [31:0] addr);
    if (i == 0) begin lif0.request = r; lif0.address = addr; end
    else        begin lif1.request = r; lif1.address = addr; end
  endtask

  // Returns at the negedge inside the cycle following the sampling edge N.
  task automatic pulse(input int i, input logic [31:0] addr);
    set_req(i, 1'b1, addr);
    @(negedge clk);
    set_req(i, 1'b0, addr);
  endtask

  task automatic collect(input int i, input int ncyc, output int nb,
                         output logic [31:0] f, output logic [31:0] l);
    nb = 0; f = '0; l = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (get_valid(i)) begin
        if (nb == 0) f = get_data(i);
        l = get_data(i);
        nb++;
      end
    end
  endtask

  typedef struct {
    int          inst;
    logic [31:0] addr;
    int          beats;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [6];
    int          nb;
    logic [31:0] f, l;

    vecs[0] = '{0, 32'h0000_0020, 8, 32'h100, 32'h107};
    vecs[1] = '{0, 32'h0000_002C, 8, 32'h100, 32'h107};
    vecs[2] = '{1, 32'h0000_003C, 8, 32'h100, 32'h107};
    vecs[3] = '{1, 32'h0000_0000, 8, 32'h0A0, 32'h0A7};
    vecs[4] = '{0, 32'h0000_4000, 8, BC ? 32'h0 : 32'h0A0, BC ? 32'h0 : 32'h0A7};
    vecs[5] = '{1, 32'h0000_4024, 8, BC ? 32'h0 : 32'h100, BC ? 32'h0 : 32'h107};

    rst = 1'b1; pw = 1'b0; pa = '0; pd = '0;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < MW; w++) write_word(32'(w * 4), $urandom());
    for (int w = 0; w < 8; w++) write_word(32'(w * 4), 32'h0A0 + 32'(w));
    for (int w = 0; w < 8; w++) write_word(32'(32 + w * 4), 32'h100 + 32'(w));
    @(negedge clk);

    // Table-driven bursts
    foreach (vecs[v]) begin
      pulse(vecs[v].inst, vecs[v].addr);
      collect(vecs[v].inst, 30, nb, f, l);
      check($sformatf("vec%0d_beats", v), 32'(nb), 32'(vecs[v].beats));
      check($sformatf("vec%0d_first", v), f, vecs[v].first);
      check($sformatf("vec%0d_last", v), l, vecs[v].last);
      check($sformatf("vec%0d_idle", v), 32'(get_busy(vecs[v].inst)), 32'h0);
    end

    // Exact timing, LATENCY=2 / BEAT_GAP=0
    pulse(0, 32'h20);
    for (int j = 0; j < 12; j++) begin
      check($sformatf("t1_valid_c%0d", j), 32'(lif0.valid), 32'(j >= 2 && j <= 9));
      check($sformatf("t1_busy_c%0d", j), 32'(busy0), 32'(j <= 9));
      @(negedge clk);
    end

    // Exact timing, LATENCY=1 / BEAT_GAP=2
    pulse(1, 32'h0);
    for (int j = 0; j < 26; j++) begin
      check($sformatf("t3_valid_c%0d", j), 32'(lif1.valid),
            32'(j >= 1 && ((j - 1) % 3) == 0 && ((j - 1) / 3) < 8));
      @(negedge clk);
    end

    // Request while busy ignored; request in the busy-fall cycle accepted
    pulse(0, 32'h20);
    nb = 0; l = '0;
    for (int j = 0; j < 10; j++) begin
      if (j == 2) set_req(0, 1'b1, 32'h0);
      if (j == 3) set_req(0, 1'b0, 32'h0);
      if (lif0.valid) begin nb++; l = lif0.data; end
      @(negedge clk);
    end
    check("t4_busy_beats", 32'(nb), 32'd8);
    check("t4_busy_last", l, 32'h107);
    check("t4_fall_busy", 32'(busy0), 32'h0);
    pulse(0, 32'h0);
    collect(0, 20, nb, f, l);
    check("t4_b2b_beats", 32'(nb), 32'd8);
    check("t4_b2b_first", f, 32'h0A0);

    // Reset after beat 3
    pulse(0, 32'h20);
    repeat (5) @(negedge clk);
    check("t5_beat3_valid", 32'(lif0.valid), 32'h1);
    check("t5_beat3_data", lif0.data, 32'h103);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_valid", 32'(lif0.valid), 32'h0);
    check("t5_rst_busy", 32'(busy0), 32'h0);
    check("t5_rst_data", lif0.data, 32'h0);
    collect(0, 12, nb, f, l);
    check("t5_no_beats", 32'(nb), 32'h0);
    pulse(0, 32'h20);
    collect(0, 20, nb, f, l);
    check("t5_retain_beats", 32'(nb), 32'd8);
    check("t5_retain_first", f, 32'h100);
    check("t5_retain_last", l, 32'h107);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      pw  = ($urandom_range(0, 3) == 0);
      pa  = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h3FFF);
      pd  = $urandom();
      for (int i = 0; i < 2; i++)
        set_req(i, $urandom_range(0, 5) == 0,
                ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h3FFF));
      @(negedge clk);
    end
    rst = 1'b0; pw = 1'b0;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
